ta_address_sequencer: RTL and testbench

TA_ADDRESS_SEQUENCER -- requirements
Module: ta_address_sequencer

---
 rtl/ta_address_sequencer_pkg.sv | 26 ++
 rtl/ta_address_sequencer_wrap_counter.sv | 47 ++++
 rtl/ta_address_sequencer.sv | 159 +++++++++++++++
 tb/tb_ta_address_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ta_address_sequencer_pkg.sv
// ============================================================================
// Module : ta_address_sequencer_pkg
// Brief  : Shared FSM encoding, width defaults and bound clamp helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ta_address_sequencer_pkg;

    localparam int CNT_W_DEF  = 17;
    localparam int ADDR_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bounds are handled at 32 bits so one helper serves any CNT_W up to 32.
    function automatic logic [31:0] clamp_bound(input logic [31:0] val, input logic [31:0] ceil);
        return (val > ceil) ? ceil : val;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ta_address_sequencer_wrap_counter.sv
// ============================================================================
// Module : ta_wrap_counter
// Brief  : Index counter that wraps at bound-1 and emits a carry on the wrap.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ta_wrap_counter #(
    parameter int CNT_W = 17
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] bound_i,
    output logic [CNT_W-1:0] idx_o,
    output logic             last_o,
    output logic             carry_o
);

    logic [CNT_W-1:0] idx_q;
    logic [CNT_W-1:0] idx_d;

    assign last_o  = (idx_q == (bound_i - CNT_W'(1)));
    assign carry_o = inc_i & last_o;
    assign idx_o   = idx_q;

    always_comb begin
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = '0;
        end else if (inc_i) begin
            idx_d = last_o ? '0 : idx_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ta_address_sequencer.sv
// ============================================================================
// Module : ta_address_sequencer
// Brief  : Nested class/clause/chunk index sweep with ready/valid beats.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ta_address_sequencer
    import ta_address_sequencer_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int MAX_CLASSES = 10,
    parameter int MAX_CLAUSES = 10,
    parameter int MAX_CHUNKS  = 10
) (
    input  logic              clk,
    input  logic              rst_flag,
    input  logic              start,
    input  logic              abort,
    input  logic              stop_flag,
    input  logic              cont_mode,
    input  logic [CNT_W-1:0]  cfg_classes,
    input  logic [CNT_W-1:0]  cfg_clauses,
    input  logic [CNT_W-1:0]  cfg_chunks,
    input  logic              beat_ready,
    output logic              beat_valid,
    output logic [CNT_W-1:0]  class_idx,
    output logic [CNT_W-1:0]  clause_idx,
    output logic [CNT_W-1:0]  chunk_idx,
    output logic [ADDR_W-1:0] lin_addr,
    output logic              first_chunk,
    output logic              last_chunk,
    output logic              last_clause,
    output logic              last_beat,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cls_bnd_q, cls_bnd_d;
    logic [CNT_W-1:0]  cla_bnd_q, cla_bnd_d;
    logic [CNT_W-1:0]  chk_bnd_q, chk_bnd_d;
    logic              cont_q, cont_d;
    logic              cfg_err_q, cfg_err_d;
    logic [ADDR_W-1:0] lin_q, lin_d;

    logic [CNT_W-1:0]  w_cls_clamp, w_cla_clamp, w_chk_clamp;
    logic              w_fire, w_clr;
    logic              w_chk_last, w_chk_carry;
    logic              w_cla_last, w_cla_carry;
    logic              w_cls_last, w_cls_carry;

    assign w_cls_clamp = CNT_W'(clamp_bound(32'(cfg_classes), 32'(MAX_CLASSES)));
    assign w_cla_clamp = CNT_W'(clamp_bound(32'(cfg_clauses), 32'(MAX_CLAUSES)));
    assign w_chk_clamp = CNT_W'(clamp_bound(32'(cfg_chunks),  32'(MAX_CHUNKS)));

    // Abort wins over a simultaneous handshake, so it also blocks the fire.
    assign beat_valid = (state_q == ST_RUN);
    assign busy       = beat_valid;
    assign w_fire     = beat_valid & beat_ready & ~stop_flag & ~abort;

    ta_wrap_counter #(.CNT_W(CNT_W)) u_chunk (
        .clk_i(clk), .rst_i(rst_flag), .clr_i(w_clr), .inc_i(w_fire),
        .bound_i(chk_bnd_q), .idx_o(chunk_idx), .last_o(w_chk_last), .carry_o(w_chk_carry)
    );

    ta_wrap_counter #(.CNT_W(CNT_W)) u_clause (
        .clk_i(clk), .rst_i(rst_flag), .clr_i(w_clr), .inc_i(w_chk_carry),
        .bound_i(cla_bnd_q), .idx_o(clause_idx), .last_o(w_cla_last), .carry_o(w_cla_carry)
    );

    ta_wrap_counter #(.CNT_W(CNT_W)) u_class (
        .clk_i(clk), .rst_i(rst_flag), .clr_i(w_clr), .inc_i(w_cla_carry),
        .bound_i(cls_bnd_q), .idx_o(class_idx), .last_o(w_cls_last), .carry_o(w_cls_carry)
    );

    assign first_chunk = beat_valid & (chunk_idx == '0);
    assign last_chunk  = beat_valid & w_chk_last;
    assign last_clause = last_chunk & w_cla_last;
    assign last_beat   = last_clause & w_cls_last;
    assign lin_addr    = lin_q;
    assign cfg_err     = cfg_err_q;

    // w_cls_carry is the fire of the final beat of a pass.
    assign done = ((state_q == ST_DONE) & ~stop_flag) | (w_cls_carry & cont_q);

    always_comb begin
        state_d   = state_q;
        cls_bnd_d = cls_bnd_q;
        cla_bnd_d = cla_bnd_q;
        chk_bnd_d = chk_bnd_q;
        cont_d    = cont_q;
        cfg_err_d = cfg_err_q;
        lin_d     = lin_q;
        w_clr     = 1'b0;
        if (!stop_flag) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if ((w_cls_clamp == '0) || (w_cla_clamp == '0) || (w_chk_clamp == '0)) begin
                            state_d   = ST_DONE;
                            cfg_err_d = 1'b1;
                        end else begin
                            state_d   = ST_RUN;
                            cls_bnd_d = w_cls_clamp;
                            cla_bnd_d = w_cla_clamp;
                            chk_bnd_d = w_chk_clamp;
                            cont_d    = cont_mode;
                            cfg_err_d = 1'b0;
                            lin_d     = '0;
                            w_clr     = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_d = ST_DONE;
                    end else if (w_cls_carry) begin
                        if (cont_q) begin
                            lin_d = '0;
                        end else begin
                            lin_d   = lin_q + ADDR_W'(1);
                            state_d = ST_DONE;
                        end
                    end else if (w_fire) begin
                        lin_d = lin_q + ADDR_W'(1);
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_flag) begin
            state_q   <= ST_IDLE;
            cls_bnd_q <= '0;
            cla_bnd_q <= '0;
            chk_bnd_q <= '0;
            cont_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            lin_q     <= '0;
        end else begin
            state_q   <= state_d;
            cls_bnd_q <= cls_bnd_d;
            cla_bnd_q <= cla_bnd_d;
            chk_bnd_q <= chk_bnd_d;
            cont_q    <= cont_d;
            cfg_err_q <= cfg_err_d;
            lin_q     <= lin_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ta_address_sequencer.sv
// ============================================================================
// Module : tb_ta_address_sequencer
// Brief  : Directed and randomized sweeps checked against a nested-loop model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ta_address_sequencer;

    logic        clk = 1'b0;
    logic        rst_flag, start, abort, stop_flag, cont_mode, beat_ready;
    logic [16:0] cfg_classes, cfg_clauses, cfg_chunks;
    logic        beat_valid, first_chunk, last_chunk, last_clause, last_beat;
    logic        busy, done, cfg_err;
    logic [16:0] class_idx, clause_idx, chunk_idx;
    logic [31:0] lin_addr;

    int tests = 0;
    int fails = 0;

    ta_address_sequencer dut (
        .clk(clk), .rst_flag(rst_flag), .start(start), .abort(abort),
        .stop_flag(stop_flag), .cont_mode(cont_mode),
        .cfg_classes(cfg_classes), .cfg_clauses(cfg_clauses), .cfg_chunks(cfg_chunks),
        .beat_ready(beat_ready), .beat_valid(beat_valid),
        .class_idx(class_idx), .clause_idx(clause_idx), .chunk_idx(chunk_idx),
        .lin_addr(lin_addr), .first_chunk(first_chunk), .last_chunk(last_chunk),
        .last_clause(last_clause), .last_beat(last_beat),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int min10(input int v);
        return (v > 10) ? 10 : v;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_done"}, done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_valid"}, beat_valid, 0);
    endtask

    // Beat k of a pass maps to (k / (el*ek), (k / ek) % el, k % ek).
    task automatic check_beat(input string tag, input int k, input int el, input int ek, input int n);
        check({tag, "_chunk"}, chunk_idx, k % ek);
        check({tag, "_clause"}, clause_idx, (k / ek) % el);
        check({tag, "_class"}, class_idx, k / (ek * el));
        check({tag, "_lin"}, lin_addr, k);
        check({tag, "_first"}, first_chunk, (k % ek) == 0);
        check({tag, "_lastchk"}, last_chunk, (k % ek) == ek - 1);
        check({tag, "_lastcla"}, last_clause, (k % (ek * el)) == ek * el - 1);
        check({tag, "_lastbeat"}, last_beat, k == n - 1);
    endtask

    task automatic run_sweep(input int cls, input int cla, input int chk, input bit cont,
                             input bit rnd_rdy, input int stop_beat, input int stop_len,
                             input int abort_beat, input int rst_beat);
        int ec, el, ek, n, k, total, stop_cnt, cyc;
        bit rdy, stp, abt, fire;
        ec = min10(cls); el = min10(cla); ek = min10(chk);
        n = ec * el * ek;
        @(negedge clk);
        start = 1'b1; cont_mode = cont;
        cfg_classes = 17'(cls); cfg_clauses = 17'(cla); cfg_chunks = 17'(chk);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cfg_classes = 17'($urandom); cfg_clauses = 17'($urandom); cfg_chunks = 17'($urandom);
        cont_mode = ~cont;
        #1;
        if (n == 0) begin
            check("zb_done", done, 1);
            check("zb_err", cfg_err, 1);
            check("zb_valid", beat_valid, 0);
            @(negedge clk); #1;
            check_idle("zb_after");
            check("zb_err_sticky", cfg_err, 1);
            return;
        end
        k = 0; total = 0; stop_cnt = 0; cyc = 0;
        forever begin
            rdy = rnd_rdy ? bit'($urandom_range(0, 1)) : 1'b1;
            stp = (total == stop_beat) && (stop_cnt < stop_len);
            abt = (total == abort_beat) && !stp;
            if (total == rst_beat) begin
                rst_flag = 1'b1; stop_flag = 1'b1; beat_ready = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rst_flag = 1'b0; stop_flag = 1'b0; #1;
                check_idle("rst");
                check("rst_class", class_idx, 0);
                check("rst_chunk", chunk_idx, 0);
                check("rst_lin", lin_addr, 0);
                check("rst_err", cfg_err, 0);
                return;
            end
            beat_ready = rdy; stop_flag = stp; abort = abt;
            if (stp) stop_cnt++;
            fire = rdy && !stp && !abt;
            #1;
            check("run_valid", beat_valid, 1);
            check("run_busy", busy, 1);
            check("run_err", cfg_err, 0);
            check("run_done", done, fire && cont && (k == n - 1));
            check_beat("beat", k, el, ek, n);
            @(posedge clk);
            @(negedge clk);
            abort = 1'b0; stop_flag = 1'b0; beat_ready = 1'b0;
            if (abt) begin
                #1;
                check("ab_done", done, 1);
                check("ab_valid", beat_valid, 0);
                check("ab_chunk", chunk_idx, k % ek);
                check("ab_clause", clause_idx, (k / ek) % el);
                check("ab_class", class_idx, k / (ek * el));
                @(negedge clk); #1;
                check_idle("ab_after");
                return;
            end
            if (fire) begin
                k++; total++;
                if (k == n) begin
                    k = 0;
                    if (!cont) begin
                        #1;
                        check("sp_done", done, 1);
                        check("sp_valid", beat_valid, 0);
                        @(negedge clk); #1;
                        check_idle("sp_after");
                        return;
                    end
                end
            end
            cyc++;
            if (cyc > 3000) begin
                check("timeout", 1, 0);
                return;
            end
            #0;
        end
    endtask

    initial begin
        rst_flag = 1'b1; start = 1'b0; abort = 1'b0; stop_flag = 1'b0; cont_mode = 1'b0;
        beat_ready = 1'b0; cfg_classes = '0; cfg_clauses = '0; cfg_chunks = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check_idle("reset");
        check("reset_err", cfg_err, 0);
        check("reset_class", class_idx, 0);
        check("reset_lin", lin_addr, 0);
        rst_flag = 1'b0;

        run_sweep(2, 3, 4, 1'b0, 1'b0, -1, 0, -1, -1);
        run_sweep(1, 1, 3, 1'b1, 1'b0, -1, 0, 10, -1);
        run_sweep(2, 2, 2, 1'b0, 1'b1, 3, 5, -1, -1);
        run_sweep(2, 2, 0, 1'b0, 1'b0, -1, 0, -1, -1);
        @(negedge clk); #1;
        check("err_held_idle", cfg_err, 1);
        run_sweep(1, 2, 2, 1'b0, 1'b0, -1, 0, -1, -1);
        run_sweep(20, 2, 2, 1'b0, 1'b0, -1, 0, -1, -1);
        run_sweep(2, 3, 4, 1'b0, 1'b0, -1, 0, -1, 5);
        run_sweep(2, 3, 4, 1'b0, 1'b0, -1, 0, 5, -1);
        for (int i = 0; i < 6; i++) begin
            run_sweep($urandom_range(1, 4), $urandom_range(1, 4),
                      (i == 5) ? 13 : $urandom_range(1, 4), 1'b0, 1'b1,
                      $urandom_range(0, 5), $urandom_range(1, 4), -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
